data_memory_sync: RTL
=====================

Name: data_memory_sync

Overview:
- Parametrised, fully synchronous successor to the team's 16x8 data memory.
- One write port and one read port.
- Registered read with write-to-read bypass.
- Built-in clear sequencer that zeroes every location after reset or on request.
- Sits beside the datapath as the load/store memory; the control FSM watches Busy before issuing accesses.

Parameters:
DATA_WIDTH, 8, bits per word
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words (default 16)
BYPASS_EN, 1, 1 = same-cycle same-address read returns Data_In; 0 = returns old contents

Ports:
Clock  input  1  sole clock, rising edge
Reset_N  input  1  asynchronous, active-low reset
Write_Enable  input  1  write request, sampled at rising Clock
Write_Address  input  ADDR_WIDTH  write word address
Data_In  input  DATA_WIDTH  write data
Read_Enable  input  1  read request, sampled at rising Clock
Read_Address  input  ADDR_WIDTH  read word address
Clear  input  1  request a zeroing sweep of the whole array
Data_Out  output  DATA_WIDTH  registered read data
Read_Valid  output  1  high one cycle when Data_Out holds a fresh read result
Busy  output  1  high while a clear sweep runs; accesses are ignored
Access_Dropped  output  1  one-cycle pulse: Write_Enable or Read_Enable asserted while Busy

Behaviour:
- Reset (Reset_N=0, asynchronous): state=SWEEP, sweep counter=0, Data_Out=0, Read_Valid=0, Busy=1, Access_Dropped=0. The array itself is not reset; the sweep clears it.
- State SWEEP:
  - Each rising edge writes 0 to location counter, then counter+1.
  - After the edge that writes DEPTH-1, move to IDLE; Busy falls on that same edge.
  - Sweep length is exactly DEPTH cycles after Reset_N deasserts.
  - Write_Enable and Read_Enable are ignored; Access_Dropped=1 in the next cycle if either was high; Read_Valid stays 0.
  - Clear is ignored.
- State IDLE:
  - Write_Enable=1: DMEM[Write_Address] <= Data_In on the edge.
  - Read_Enable=1: on the edge, Data_Out <= DMEM[Read_Address] and Read_Valid <= 1. Latency is 1 cycle.
  - Read_Enable=0: Read_Valid <= 0 and Data_Out holds its previous value.
  - Simultaneous read and write, same address: BYPASS_EN=1 gives Data_Out=Data_In; BYPASS_EN=0 gives the pre-write contents.
  - Simultaneous read and write, different addresses: both complete independently.
  - Clear=1: go to SWEEP with counter=0; Busy=1 from the next cycle. Clear has priority over a write in the same cycle (the write is discarded, no Access_Dropped). A read in that cycle still completes.
- Reset asserted mid-sweep or mid-access: state, outputs and counter go to reset values immediately. A full sweep restarts after release.
- Address wrap: the counter is ADDR_WIDTH+1 bits internally; terminal detection is at DEPTH-1, with no wrap past it.
- Data_Out only changes on a valid read or on reset.
- No combinational path from inputs to outputs.

Test Plan:
- Release Reset_N, hold all requests low -> Busy=1 for exactly 16 cycles, then 0. Reads of addresses 0..15 each return 0x00 with Read_Valid pulsing per read.
- IDLE: write 0xA5 to addr 3, then next cycle read addr 3 -> one cycle later Data_Out=0xA5, Read_Valid=1. Read addr 4 -> 0x00.
- Same cycle: write 0x3C to addr 7 and read addr 7 (addr 7 previously 0x11) -> BYPASS_EN=1 gives Data_Out=0x3C; BYPASS_EN=0 gives 0x11. A follow-up read returns 0x3C in both cases.
- Fill addr 0..15 with values 0x10..0x1F, pulse Clear together with a write of 0xFF to addr 2 -> Busy high 16 cycles. Write_Enable asserted during the sweep gives Access_Dropped pulses. Afterwards every address reads 0x00; addr 2 is not 0xFF.
- Assert Reset_N=0 at sweep cycle 5 for 2 cycles -> Data_Out=0 and Read_Valid=0 immediately; after release Busy lasts a full 16 cycles.
- Parametrise DATA_WIDTH=16, ADDR_WIDTH=6 -> sweep takes 64 cycles. Write 0xBEEF to addr 63 and read it back gives 0xBEEF. A read of addr 0 is unaffected.

Source files
------------

// File: rtl/data_memory_sync.sv
// data_memory_sync: parametrised synchronous load/store data memory.
//
// One write port and one registered read port over a DEPTH = 2**ADDR_WIDTH
// word array. A built-in clear sequencer sweeps zeros through every location
// after reset and whenever Clear is requested; accesses are refused while it
// runs. The array itself has no reset, so the sweep is its only
// initialisation.
//
// Ports:
//   Clock          - sole clock, rising edge
//   Reset_N        - asynchronous active-low reset
//   Write_Enable   - write request, sampled at rising Clock
//   Write_Address  - write word address
//   Data_In        - write data
//   Read_Enable    - read request, sampled at rising Clock
//   Read_Address   - read word address
//   Clear          - request a zeroing sweep of the whole array
//   Data_Out       - registered read data; holds between valid reads
//   Read_Valid     - high for one cycle when Data_Out carries a fresh result
//   Busy           - high while a clear sweep runs
//   Access_Dropped - one-cycle pulse after a request arrived while Busy
module data_memory_sync #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          BYPASS_EN  = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset_N,
  input  logic                  Write_Enable,
  input  logic [ADDR_WIDTH-1:0] Write_Address,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Read_Enable,
  input  logic [ADDR_WIDTH-1:0] Read_Address,
  input  logic                  Clear,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Read_Valid,
  output logic                  Busy,
  output logic                  Access_Dropped
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  // The sweep counter carries one extra bit so the terminal compare is a
  // plain equality against the last address rather than relying on a wrap.
  localparam logic [ADDR_WIDTH:0] LastCnt = (ADDR_WIDTH + 1)'(Depth - 1);
  localparam logic [ADDR_WIDTH:0] CntOne  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [0:0] {
    StSweep,
    StIdle
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  drop_q, drop_d;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  // Single physical write port shared by the sweep and the user.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  rd_fire;
  logic                  bypass_hit;
  logic [DATA_WIDTH-1:0] rd_data;

  // Next-state, write-port steering and drop detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = Write_Address;
    mem_wdata = Data_In;
    rd_fire   = 1'b0;
    drop_d    = 1'b0;

    unique case (state_q)
      StSweep: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_WIDTH-1:0];
        mem_wdata = '0;
        drop_d    = Write_Enable | Read_Enable;
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StIdle: begin
        // A read issued alongside Clear still completes.
        rd_fire = Read_Enable;
        if (Clear) begin
          // Clear wins over a same-cycle write, which is silently discarded.
          state_d = StSweep;
          cnt_d   = '0;
        end else if (Write_Enable) begin
          mem_we = 1'b1;
        end
      end
      default: begin
        state_d = StSweep;
        cnt_d   = '0;
      end
    endcase
  end

  // Same-address forwarding only applies to a write that actually commits.
  always_comb begin
    bypass_hit = BYPASS_EN && (state_q == StIdle) && Write_Enable && !Clear &&
                 (Write_Address == Read_Address);
    rd_data    = bypass_hit ? Data_In : mem_q[Read_Address];
  end

  always_comb begin
    valid_d = rd_fire;
    dout_d  = rd_fire ? rd_data : dout_q;
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= StSweep;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Storage array: deliberately unreset, initialised by the sweep.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign Data_Out       = dout_q;
  assign Read_Valid     = valid_q;
  assign Busy           = (state_q == StSweep);
  assign Access_Dropped = drop_q;

endmodule
